// File: rtl/z80_io_responder.sv
// Z80 I/O-cycle responder: 4-register port block at BASE_ADDR, programmable WAIT_L
// insertion, IM2 interrupt request/vector supply on the shared tri-state data bus.
module z80_io_responder #(
    parameter logic [7:0] BASE_ADDR   = 8'h10,
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] IM2_VECTOR  = 8'hE0
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [15:0] addr_bus,
    inout  wire  [7:0]  data_bus,
    input  logic        M1_L,
    input  logic        MREQ_L,
    input  logic        IORQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    output logic        WAIT_L,
    output logic        INT_L,
    input  logic        irq_req,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_INTA   = 3'd4
    } state_t;

    localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic [7:0] r_data_out;
    logic [7:0] r_din;
    logic [7:0] r_vector;
    logic       r_ie;
    logic       r_pend;
    logic       r_irq_d;

    logic       w_hit;
    logic       w_inta;
    logic       w_wr;
    logic       w_pend_set;
    logic       w_pend_clr;
    logic       w_drv_rd;
    logic       w_drv_vec;
    logic [7:0] w_rdata;
    logic [7:0] w_wdata;
    logic [1:0] w_off;
    wire        w_unused = &{1'b0, addr_bus[15:8]};

    assign w_off   = addr_bus[1:0];
    assign w_wdata = data_bus;
    assign w_hit   = !IORQ_L && M1_L && MREQ_L && (addr_bus[7:2] == BASE_ADDR[7:2])
                     && (!RD_L || !WR_L);
    assign w_inta  = !IORQ_L && !M1_L;
    // An aborted cycle (IORQ_L already high in ACCESS) must not commit the write.
    assign w_wr    = (r_state == S_ACCESS) && !IORQ_L && !WR_L;

    // State register and wait counter
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_hit)
                r_cnt <= CNT_INIT;
            else if (r_state == S_WAIT && r_cnt != 3'd0)
                r_cnt <= r_cnt - 3'd1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_inta)
                    w_next = S_INTA;
                else if (w_hit)
                    w_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            end
            S_WAIT: begin
                if (IORQ_L)
                    w_next = S_IDLE;
                else if (r_cnt == 3'd0)
                    w_next = S_ACCESS;
            end
            S_ACCESS: w_next = IORQ_L ? S_IDLE : S_DONE;
            S_DONE:   if (IORQ_L) w_next = S_IDLE;
            S_INTA:   if (IORQ_L) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        WAIT_L    = (r_state != S_WAIT);
        w_drv_rd  = (r_state == S_WAIT || r_state == S_ACCESS || r_state == S_DONE)
                    && !RD_L && !IORQ_L;
        w_drv_vec = (r_state == S_INTA) && !IORQ_L && !M1_L;
    end

    // DATA_IN shows the live pin while waiting, then the value captured entering ACCESS.
    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            2'd0: w_rdata = r_data_out;
            2'd1: w_rdata = (r_state == S_WAIT) ? port_in : r_din;
            2'd2: w_rdata = {6'b0, r_pend, r_ie};
            2'd3: w_rdata = r_vector;
            default: w_rdata = 8'h00;
        endcase
    end

    assign data_bus = w_drv_vec ? r_vector : (w_drv_rd ? w_rdata : 8'hzz);

    assign w_pend_set = irq_req && !r_irq_d;
    assign w_pend_clr = (w_wr && w_off == 2'd2 && w_wdata[1])
                        || (r_state == S_INTA && IORQ_L);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_data_out <= 8'h00;
            r_din      <= 8'h00;
            r_vector   <= IM2_VECTOR;
            r_ie       <= 1'b0;
            r_pend     <= 1'b0;
            r_irq_d    <= 1'b0;
        end else begin
            r_irq_d <= irq_req;
            if (r_state != S_ACCESS && w_next == S_ACCESS)
                r_din <= port_in;
            if (w_wr) begin
                case (w_off)
                    2'd0:    r_data_out <= w_wdata;
                    2'd2:    r_ie       <= w_wdata[0];
                    2'd3:    r_vector   <= w_wdata;
                    default: ;
                endcase
            end
            // A new event on the same edge as a clear keeps the interrupt pending.
            if (w_pend_set)
                r_pend <= 1'b1;
            else if (w_pend_clr)
                r_pend <= 1'b0;
        end
    end

    assign INT_L    = !(r_pend && r_ie);
    assign port_out = r_data_out;

endmodule

// File: tb/tb_z80_io_responder.sv
// Directed bench for z80_io_responder; released bus reads back as 8'hFF via the pull-up.
module tb_z80_io_responder;

    logic        clk;
    logic        rst_L;
    logic [15:0] addr_bus;
    tri1  [7:0]  data_bus;
    logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L;
    logic        WAIT_L, INT_L;
    logic        irq_req;
    logic [7:0]  port_in, port_out;
    logic        tb_drv;
    logic [7:0]  tb_dat;

    int n_checks = 0;
    int n_errors = 0;

    assign data_bus = tb_drv ? tb_dat : 8'hzz;

    z80_io_responder #(.BASE_ADDR(8'h10), .WAIT_STATES(1), .IM2_VECTOR(8'hE0)) dut (
        .clk(clk), .rst_L(rst_L), .addr_bus(addr_bus), .data_bus(data_bus),
        .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
        .WAIT_L(WAIT_L), .INT_L(INT_L), .irq_req(irq_req),
        .port_in(port_in), .port_out(port_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full I/O cycle: waits counted, bus sampled in DONE, and again right after release.
    task automatic io_cycle(input logic [7:0] a, input bit wr, input logic [7:0] wd,
                            output int waits, output logic [7:0] rd, output logic [7:0] rel);
        addr_bus = {8'h00, a};
        if (wr) begin
            tb_drv = 1'b1;
            tb_dat = wd;
            WR_L   = 1'b0;
        end else begin
            RD_L = 1'b0;
        end
        IORQ_L = 1'b0;
        waits  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!WAIT_L) waits++;
        end
        rd     = data_bus;
        IORQ_L = 1'b1;
        RD_L   = 1'b1;
        WR_L   = 1'b1;
        tb_drv = 1'b0;
        #1;
        rel = data_bus;
        tick();
    endtask

    task automatic pulse_irq();
        irq_req = 1'b1;
        tick();
        irq_req = 1'b0;
        tick();
    endtask

    int         w;
    logic [7:0] rd, rel;

    initial begin
        rst_L = 1'b0; addr_bus = 16'h0000; M1_L = 1'b1; MREQ_L = 1'b1; IORQ_L = 1'b1;
        RD_L = 1'b1; WR_L = 1'b1; irq_req = 1'b0; port_in = 8'h00; tb_drv = 1'b0; tb_dat = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wait_l", 16'(WAIT_L), 16'h1);
        check("rst_int_l", 16'(INT_L), 16'h1);
        check("rst_port_out", 16'(port_out), 16'h00);
        check("rst_bus", 16'(data_bus), 16'hFF);
        rst_L = 1'b1;
        tick();
        io_cycle(8'h13, 1'b0, 8'h00, w, rd, rel);
        check("rst_vector", 16'(rd), 16'hE0);

        // OUT (10h),A5h
        io_cycle(8'h10, 1'b1, 8'hA5, w, rd, rel);
        check("out_waits", 16'(w), 16'd1);
        check("out_port_out", 16'(port_out), 16'hA5);
        io_cycle(8'h10, 1'b0, 8'h00, w, rd, rel);
        check("out_readback", 16'(rd), 16'hA5);

        // IN (11h): captured on entry to ACCESS, held even if the pin changes
        port_in  = 8'h3C;
        addr_bus = 16'h0011;
        RD_L = 1'b0; IORQ_L = 1'b0;
        tick();
        check("in_wait_l", 16'(WAIT_L), 16'h0);
        check("in_bus_wait", 16'(data_bus), 16'h3C);
        tick();
        port_in = 8'h99;
        #1;
        check("in_bus_access", 16'(data_bus), 16'h3C);
        tick();
        check("in_bus_done", 16'(data_bus), 16'h3C);
        RD_L = 1'b1; IORQ_L = 1'b1;
        #1;
        check("in_bus_release", 16'(data_bus), 16'hFF);
        tick();

        // Non-decoded I/O and memory write to the same low address
        io_cycle(8'h14, 1'b1, 8'hFF, w, rd, rel);
        check("nodec_waits", 16'(w), 16'd0);
        check("nodec_port_out", 16'(port_out), 16'hA5);
        check("nodec_bus", 16'(rel), 16'hFF);
        addr_bus = 16'h0010; MREQ_L = 1'b0; WR_L = 1'b0; tb_drv = 1'b1; tb_dat = 8'h77;
        w = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!WAIT_L) w++;
        end
        MREQ_L = 1'b1; WR_L = 1'b1; tb_drv = 1'b0;
        tick();
        check("mreq_waits", 16'(w), 16'd0);
        check("mreq_port_out", 16'(port_out), 16'hA5);

        // Aborted write: IORQ_L rises while waiting
        addr_bus = 16'h0010; tb_drv = 1'b1; tb_dat = 8'h11; WR_L = 1'b0; IORQ_L = 1'b0;
        tick();
        IORQ_L = 1'b1; WR_L = 1'b1; tb_drv = 1'b0;
        tick();
        tick();
        check("abort_port_out", 16'(port_out), 16'hA5);
        check("abort_wait_l", 16'(WAIT_L), 16'h1);

        // Interrupt request and IM2 acknowledge
        io_cycle(8'h12, 1'b1, 8'h01, w, rd, rel);
        check("ie_int_l_idle", 16'(INT_L), 16'h1);
        irq_req = 1'b1;
        tick();
        check("irq_int_l", 16'(INT_L), 16'h0);
        irq_req = 1'b0;
        io_cycle(8'h12, 1'b0, 8'h00, w, rd, rel);
        check("ctrl_read", 16'(rd), 16'h03);
        M1_L = 1'b0; IORQ_L = 1'b0;
        tick();
        check("inta_vector", 16'(data_bus), 16'hE0);
        check("inta_wait_l", 16'(WAIT_L), 16'h1);
        IORQ_L = 1'b1; M1_L = 1'b1;
        #1;
        check("inta_release", 16'(data_bus), 16'hFF);
        tick();
        check("inta_int_l", 16'(INT_L), 16'h1);

        // W1C on the same edge as a new irq edge: set wins
        pulse_irq();
        check("pend_again", 16'(INT_L), 16'h0);
        addr_bus = 16'h0012; tb_drv = 1'b1; tb_dat = 8'h03; WR_L = 1'b0; IORQ_L = 1'b0;
        tick();
        tick();
        irq_req = 1'b1;
        tick();
        check("w1c_race_int_l", 16'(INT_L), 16'h0);
        IORQ_L = 1'b1; WR_L = 1'b1; tb_drv = 1'b0;
        tick();
        irq_req = 1'b0;
        tick();
        io_cycle(8'h12, 1'b1, 8'h03, w, rd, rel);
        check("w1c_int_l", 16'(INT_L), 16'h1);
        io_cycle(8'h12, 1'b0, 8'h00, w, rd, rel);
        check("w1c_ctrl", 16'(rd), 16'h01);

        // Rewritten vector is supplied on the next acknowledge
        io_cycle(8'h13, 1'b1, 8'h5A, w, rd, rel);
        M1_L = 1'b0; IORQ_L = 1'b0;
        tick();
        check("inta_vector_new", 16'(data_bus), 16'h5A);
        IORQ_L = 1'b1; M1_L = 1'b1;
        tick();

        // Reset asserted in the middle of a waited read
        pulse_irq();
        check("pre_rst_int_l", 16'(INT_L), 16'h0);
        addr_bus = 16'h0013; RD_L = 1'b0; IORQ_L = 1'b0;
        tick();
        check("pre_rst_wait_l", 16'(WAIT_L), 16'h0);
        check("pre_rst_bus", 16'(data_bus), 16'h5A);
        rst_L = 1'b0;
        #1;
        check("mid_rst_wait_l", 16'(WAIT_L), 16'h1);
        check("mid_rst_bus", 16'(data_bus), 16'hFF);
        check("mid_rst_int_l", 16'(INT_L), 16'h1);
        check("mid_rst_port_out", 16'(port_out), 16'h00);
        RD_L = 1'b1; IORQ_L = 1'b1;
        tick();
        rst_L = 1'b1;
        tick();
        io_cycle(8'h13, 1'b0, 8'h00, w, rd, rel);
        check("post_rst_vector", 16'(rd), 16'hE0);
        io_cycle(8'h12, 1'b0, 8'h00, w, rd, rel);
        check("post_rst_ctrl", 16'(rd), 16'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
